fpu_fpr_wb_ctl: RTL and testbench

//  Write-side controller for the 32-entry FP register file; drives its single write port (wen0/waddr0/wd0).

---
 rtl/fpu_fpr_wb_if.sv | 40 ++++
 rtl/fpu_fpr_wb_ctl.sv | 112 +++++++++++
 tb/tb_fpu_fpr_wb_ctl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_fpr_wb_if.sv
// Issue, result-source and register-file write signals of the FPR write-back controller.
// The controller takes the slave side; the issue stage, FPU pipe and div/sqrt unit take the master side.
interface fpu_fpr_wb_if #(
  parameter int FPLEN = 16
);
  logic             issue_valid;
  logic             issue_fpwr;
  logic [4:0]       issue_rd;
  logic             rden0, rden1, rden2;
  logic [4:0]       raddr0, raddr1, raddr2;
  logic             a_valid;
  logic [4:0]       a_addr;
  logic [FPLEN-1:0] a_data;
  logic             a_stall;
  logic             b_valid;
  logic             b_ready;
  logic [4:0]       b_addr;
  logic [FPLEN-1:0] b_data;
  logic             wen0;
  logic [4:0]       waddr0;
  logic [FPLEN-1:0] wd0;
  logic [31:0]      pending;
  logic             hazard;

  modport master (
    output issue_valid, issue_fpwr, issue_rd,
    output rden0, rden1, rden2, raddr0, raddr1, raddr2,
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_stall, b_ready, wen0, waddr0, wd0, pending, hazard
  );

  modport slave (
    input  issue_valid, issue_fpwr, issue_rd,
    input  rden0, rden1, rden2, raddr0, raddr1, raddr2,
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_stall, b_ready, wen0, waddr0, wd0, pending, hazard
  );
endinterface

// File: rtl/fpu_fpr_wb_ctl.sv
// FP register-file write-port controller: merges pipe (A) and div/sqrt (B) results,
// buffers B in a small FIFO with a starvation guard, and tracks pending writes for RAW/WAW stalls.
module fpu_fpr_wb_ctl #(
  parameter int FPLEN      = 16,
  parameter int BDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst_l,
  fpu_fpr_wb_if.slave  bus
);
  localparam int AW = $clog2(BDEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_addr [BDEPTH];
  logic [FPLEN-1:0] fifo_data [BDEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  logic [SW-1:0]    starve_left;
  logic             force_b, grant_a, grant_b;

  logic             wen_q;
  logic [4:0]       waddr_q;
  logic [FPLEN-1:0] wd_q;

  logic [31:0]      pending_q, pending_nxt;
  logic             hazard_raw, sb_set;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // starve_left counts down A grants taken while B waits; zero forces the B head out.
  always_comb begin
    force_b = !fifo_empty && (starve_left == '0);
    grant_a = bus.a_valid && !force_b;
    grant_b = force_b || (!bus.a_valid && !fifo_empty);
    push    = rst_l && bus.b_valid && !fifo_full;
    pop     = grant_b;
  end

  assign bus.b_ready = rst_l && !fifo_full;
  assign bus.a_stall = rst_l && bus.a_valid && force_b;

  always_comb begin
    hazard_raw = (bus.rden0 && pending_q[bus.raddr0])
              || (bus.rden1 && pending_q[bus.raddr1])
              || (bus.rden2 && pending_q[bus.raddr2])
              || (bus.issue_fpwr && pending_q[bus.issue_rd]);
    sb_set     = bus.issue_valid && bus.issue_fpwr && !hazard_raw;
  end

  assign bus.hazard = rst_l && hazard_raw;

  // A new issue to the FPR being retired this cycle must stay pending, so set overrides clear.
  always_comb begin
    pending_nxt = pending_q;
    if (wen_q)
      pending_nxt[waddr_q] = 1'b0;
    if (sb_set)
      pending_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      starve_left <= SW'(STARVE_MAX);
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wd_q        <= '0;
      pending_q   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (grant_b || fifo_empty)
        starve_left <= SW'(STARVE_MAX);
      else if (grant_a)
        starve_left <= starve_left - 1'b1;

      if (grant_a) begin
        wen_q   <= 1'b1;
        waddr_q <= bus.a_addr;
        wd_q    <= bus.a_data;
      end else if (grant_b) begin
        wen_q   <= 1'b1;
        waddr_q <= fifo_addr[rd_ptr[AW-1:0]];
        wd_q    <= fifo_data[rd_ptr[AW-1:0]];
      end else begin
        wen_q   <= 1'b0;
      end

      pending_q <= pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= bus.b_addr;
      fifo_data[wr_ptr[AW-1:0]] <= bus.b_data;
    end
  end

  assign bus.wen0    = wen_q;
  assign bus.waddr0  = waddr_q;
  assign bus.wd0     = wd_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_fpu_fpr_wb_ctl.sv
// Directed bench for fpu_fpr_wb_ctl: reset, single-source writes, starvation guard,
// FIFO back-pressure, scoreboard hazards and reset in mid-operation.
module tb_fpu_fpr_wb_ctl;
  logic clk = 1'b0;
  logic rst_l;
  int   n_tests = 0;
  int   n_fail  = 0;

  fpu_fpr_wb_if #(.FPLEN(16)) bus();

  fpu_fpr_wb_ctl #(.FPLEN(16), .BDEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_fpwr = 1'b0; bus.issue_rd = 5'd0;
    bus.rden0 = 1'b0; bus.rden1 = 1'b0; bus.rden2 = 1'b0;
    bus.raddr0 = 5'd0; bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    bus.a_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 16'h0;
    bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 16'h0;
  endtask

  task automatic test_reset();
    idle();
    rst_l = 1'b0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.rden0 = 1'b1; bus.issue_fpwr = 1'b1;
    #1;
    n_tests++; if (bus.a_stall !== 1'b0) begin n_fail++; $display("FAIL rst_a_stall: got %b want 0", bus.a_stall); end
    n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b want 0", bus.b_ready); end
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %b want 0", bus.hazard); end
    tick();
    tick();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL rst_wen0: got %b want 0", bus.wen0); end
    n_tests++; if (bus.waddr0 !== 5'd0) begin n_fail++; $display("FAIL rst_waddr0: got %0d want 0", bus.waddr0); end
    n_tests++; if (bus.wd0 !== 16'h0) begin n_fail++; $display("FAIL rst_wd0: got %h want 0000", bus.wd0); end
    n_tests++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", bus.pending); end
    idle();
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_a_only();
    bus.issue_valid = 1'b1; bus.issue_fpwr = 1'b1; bus.issue_rd = 5'd3;
    tick();
    n_tests++; if (bus.pending !== 32'h8) begin n_fail++; $display("FAIL a_issue_pending: got %h want 00000008", bus.pending); end
    idle();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 16'h3C00;
    #1;
    n_tests++; if (bus.a_stall !== 1'b0) begin n_fail++; $display("FAIL a_stall: got %b want 0", bus.a_stall); end
    tick();
    n_tests++; if (bus.wen0 !== 1'b1) begin n_fail++; $display("FAIL a_wen0: got %b want 1", bus.wen0); end
    n_tests++; if (bus.waddr0 !== 5'd3) begin n_fail++; $display("FAIL a_waddr0: got %0d want 3", bus.waddr0); end
    n_tests++; if (bus.wd0 !== 16'h3C00) begin n_fail++; $display("FAIL a_wd0: got %h want 3c00", bus.wd0); end
    n_tests++; if (bus.pending !== 32'h8) begin n_fail++; $display("FAIL a_pending_held: got %h want 00000008", bus.pending); end
    idle();
    tick();
    n_tests++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL a_pending_clr: got %h want 0", bus.pending); end
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL a_wen0_off: got %b want 0", bus.wen0); end
    n_tests++; if (bus.waddr0 !== 5'd3 || bus.wd0 !== 16'h3C00) begin
      n_fail++; $display("FAIL a_hold: got %0d/%h want 3/3c00", bus.waddr0, bus.wd0);
    end
  endtask

  task automatic test_b_only();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 16'h4000;
    #1;
    n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL b_ready: got %b want 1", bus.b_ready); end
    tick();
    idle();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL b_early_wen0: got %b want 0", bus.wen0); end
    tick();
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd7 || bus.wd0 !== 16'h4000) begin
      n_fail++; $display("FAIL b_write: got %b/%0d/%h want 1/7/4000", bus.wen0, bus.waddr0, bus.wd0);
    end
    tick();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL b_no_dup: got %b want 0", bus.wen0); end
  endtask

  task automatic test_starvation();
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 16'h1234;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'(10 + i); bus.a_data = 16'(16'h0100 + i);
      #1;
      n_tests++; if (bus.a_stall !== 1'b0) begin n_fail++; $display("FAIL starve_stall_%0d: got %b want 0", i, bus.a_stall); end
      tick();
      n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'(10 + i) || bus.wd0 !== 16'(16'h0100 + i)) begin
        n_fail++; $display("FAIL starve_a_%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.wen0, bus.waddr0, bus.wd0, 10 + i, 16'h0100 + i);
      end
    end
    bus.a_addr = 5'd14; bus.a_data = 16'h0104;
    #1;
    n_tests++; if (bus.a_stall !== 1'b1) begin n_fail++; $display("FAIL starve_force: got %b want 1", bus.a_stall); end
    tick();
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd9 || bus.wd0 !== 16'h1234) begin
      n_fail++; $display("FAIL starve_b: got %b/%0d/%h want 1/9/1234", bus.wen0, bus.waddr0, bus.wd0);
    end
    n_tests++; if (bus.a_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b want 0", bus.a_stall); end
    tick();
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd14 || bus.wd0 !== 16'h0104) begin
      n_fail++; $display("FAIL starve_resume: got %b/%0d/%h want 1/14/0104", bus.wen0, bus.waddr0, bus.wd0);
    end
    idle();
    tick();
  endtask

  task automatic test_fifo_full();
    bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_data = 16'hA020;
    bus.b_valid = 1'b1; bus.b_addr = 5'd21; bus.b_data = 16'hB001;
    #1;
    n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy0: got %b want 1", bus.b_ready); end
    tick();
    bus.b_addr = 5'd22; bus.b_data = 16'hB002;
    #1;
    n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy1: got %b want 1", bus.b_ready); end
    tick();
    bus.b_addr = 5'd23; bus.b_data = 16'hB003;
    #1;
    n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy2: got %b want 0", bus.b_ready); end
    tick();
    n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy3: got %b want 0", bus.b_ready); end
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd20) begin
      n_fail++; $display("FAIL full_a_write: got %b/%0d want 1/20", bus.wen0, bus.waddr0);
    end
    tick();
    bus.a_valid = 1'b0;
    #1;
    n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_fallthru: got %b want 0", bus.b_ready); end
    tick();
    n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy_after_pop: got %b want 1", bus.b_ready); end
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd21 || bus.wd0 !== 16'hB001) begin
      n_fail++; $display("FAIL full_b21: got %b/%0d/%h want 1/21/b001", bus.wen0, bus.waddr0, bus.wd0);
    end
    tick();
    idle();
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd22 || bus.wd0 !== 16'hB002) begin
      n_fail++; $display("FAIL full_b22: got %b/%0d/%h want 1/22/b002", bus.wen0, bus.waddr0, bus.wd0);
    end
    tick();
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd23 || bus.wd0 !== 16'hB003) begin
      n_fail++; $display("FAIL full_b23: got %b/%0d/%h want 1/23/b003", bus.wen0, bus.waddr0, bus.wd0);
    end
    tick();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", bus.wen0); end
  endtask

  task automatic test_scoreboard();
    bus.issue_valid = 1'b1; bus.issue_fpwr = 1'b1; bus.issue_rd = 5'd5;
    #1;
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL sb_first_issue: got %b want 0", bus.hazard); end
    tick();
    n_tests++; if (bus.pending !== 32'h20) begin n_fail++; $display("FAIL sb_set5: got %h want 00000020", bus.pending); end
    #1;
    n_tests++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL sb_waw: got %b want 1", bus.hazard); end
    idle();
    bus.rden2 = 1'b0; bus.raddr2 = 5'd5;
    #1;
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL sb_rden_mask: got %b want 0", bus.hazard); end
    bus.rden1 = 1'b1; bus.raddr1 = 5'd5;
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 16'h5555;
    #1;
    n_tests++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL sb_raw: got %b want 1", bus.hazard); end
    tick();
    bus.a_valid = 1'b0;
    n_tests++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd5 || bus.hazard !== 1'b1) begin
      n_fail++; $display("FAIL sb_raw_at_write: got %b/%0d/%b want 1/5/1", bus.wen0, bus.waddr0, bus.hazard);
    end
    tick();
    n_tests++; if (bus.pending !== 32'h0 || bus.hazard !== 1'b0) begin
      n_fail++; $display("FAIL sb_cleared: got %h/%b want 0/0", bus.pending, bus.hazard);
    end
    idle();
    bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 16'h6666;
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_fpwr = 1'b1; bus.issue_rd = 5'd6;
    tick();
    idle();
    n_tests++; if (bus.pending !== 32'h40) begin n_fail++; $display("FAIL sb_set_wins: got %h want 00000040", bus.pending); end
    bus.a_valid = 1'b1; bus.a_addr = 5'd6;
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_fpwr = 1'b1; bus.issue_rd = 5'd0;
    tick();
    idle();
    bus.rden0 = 1'b1; bus.raddr0 = 5'd0;
    #1;
    n_tests++; if (bus.pending !== 32'h1 || bus.hazard !== 1'b1) begin
      n_fail++; $display("FAIL sb_fpr0: got %h/%b want 00000001/1", bus.pending, bus.hazard);
    end
    bus.a_valid = 1'b1; bus.a_addr = 5'd0;
    tick();
    bus.a_valid = 1'b0;
    tick();
    idle();
    n_tests++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL sb_fpr0_clr: got %h want 0", bus.pending); end
  endtask

  task automatic test_reset_midflight();
    bus.issue_valid = 1'b1; bus.issue_fpwr = 1'b1; bus.issue_rd = 5'd5;
    tick();
    bus.issue_rd = 5'd9;
    tick();
    idle();
    n_tests++; if (bus.pending !== 32'h0000_0220) begin n_fail++; $display("FAIL mid_pending: got %h want 00000220", bus.pending); end
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 16'h1111;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 16'h9999;
    tick();
    bus.b_valid = 1'b0;
    bus.rden0 = 1'b1; bus.raddr0 = 5'd5;
    rst_l = 1'b0;
    #1;
    n_tests++; if (bus.a_stall !== 1'b0 || bus.b_ready !== 1'b0 || bus.hazard !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_comb: got %b/%b/%b want 0/0/0", bus.a_stall, bus.b_ready, bus.hazard);
    end
    tick();
    n_tests++; if (bus.wen0 !== 1'b0 || bus.waddr0 !== 5'd0 || bus.wd0 !== 16'h0 || bus.pending !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_regs: got %b/%0d/%h/%h want 0/0/0000/0", bus.wen0, bus.waddr0, bus.wd0, bus.pending);
    end
    rst_l = 1'b1;
    bus.a_valid = 1'b0;
    #1;
    n_tests++; if (bus.b_ready !== 1'b1 || bus.hazard !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got %b/%b want 1/0", bus.b_ready, bus.hazard);
    end
    tick();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_flushed0: got %b want 0", bus.wen0); end
    tick();
    n_tests++; if (bus.wen0 !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_flushed1: got %b want 0", bus.wen0); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_only();
    test_b_only();
    test_starvation();
    test_fifo_full();
    test_scoreboard();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
